// File: rtl/decode_stage_hs.sv
// decode_stage_hs: decode with bypassed 8-entry register file, pending-write
// scoreboard for RAW stalls, and a valid/ready ID/EX register with flush.
module decode_stage_hs #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              wb_en,
  input  logic [2:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_r1,
  output logic [DATA_W-1:0] out_r2,
  output logic              out_regwrt,
  output logic [2:0]        out_rd,
  output logic              stall,
  output logic              err
);

  typedef struct packed {
    logic [15:0]       instr;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic              regwrt;
    logic [2:0]        rd;
  } id_ex_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [4:0]        op;
  logic [2:0]        rs;
  logic [2:0]        rt;
  logic [2:0]        rd;
  logic              regwrt;
  logic              rs_used;
  logic              rt_used;
  logic              hit_rs;
  logic              hit_rt;
  logic              blk_rs;
  logic              blk_rt;
  logic              hazard;
  logic              full;
  logic              issue;
  logic              squash;
  logic [DATA_W-1:0] r1_v;
  logic [DATA_W-1:0] r2_v;
  logic [DATA_W-1:0] rf [8];
  logic [CNT_W-1:0]  cnt [8];
  logic [CNT_W-1:0]  cnt_nx [8];
  logic [CNT_W:0]    up [8];
  logic [CNT_W:0]    dn [8];
  logic [7:0]        uf;
  id_ex_t            ex_q;
  id_ex_t            ex_d;

  assign op = in_instr[15:11];
  assign rs = in_instr[10:8];
  assign rt = in_instr[7:5];

  assign regwrt = ~((op[4:2] == 3'b011)
                  | (op[4:1] == 4'b0000)
                  | (op[4:1] == 4'b0001)
                  | (op[4:1] == 4'b0010)
                  | (op == 5'b10000));

  always_comb begin
    rd = in_instr[7:5];
    unique case (1'b1)
      (op == 5'b11011) | (op == 5'b11010) | (op[4:2] == 3'b111):
        rd = in_instr[4:2];
      (op == 5'b10010) | (op == 5'b11000):
        rd = in_instr[10:8];
      (op[4:1] == 4'b0011):
        rd = 3'd7;
      default:
        rd = in_instr[7:5];
    endcase
  end

  assign rs_used = ~(op inside {5'b00000, 5'b00001, 5'b00010,
                                5'b00011, 5'b00100, 5'b00110,
                                5'b11000});
  assign rt_used = (op inside {5'b11011, 5'b11010, 5'b10000,
                               5'b10001, 5'b10011})
                 | (op[4:2] == 3'b111);

  assign hit_rs = wb_en & (wb_reg == rs);
  assign hit_rt = wb_en & (wb_reg == rt);
  assign r1_v   = hit_rs ? wb_data : rf[rs];
  assign r2_v   = hit_rt ? wb_data : rf[rt];

  // A single pending write may retire this very cycle and be bypassed.
  assign blk_rs = (cnt[rs] > CNT_ONE) | ((cnt[rs] == CNT_ONE) & ~hit_rs);
  assign blk_rt = (cnt[rt] > CNT_ONE) | ((cnt[rt] == CNT_ONE) & ~hit_rt);

  assign hazard   = (rs_used & blk_rs) | (rt_used & blk_rt);
  assign full     = regwrt & (cnt[rd] == CNT_MAX);
  assign in_ready = ~flush & ~hazard & ~full & (~out_valid | out_ready);
  assign stall    = in_valid & (hazard | full);
  assign issue    = in_valid & in_ready;
  assign squash   = flush & out_valid;

  assign ex_d = '{in_instr, in_pc, r1_v, r2_v, regwrt, rd};

  always_comb begin
    for (int r = 0; r < 8; r++) begin
      up[r] = {1'b0, cnt[r]}
            + {{CNT_W{1'b0}}, issue & regwrt & (rd == 3'(r))};
      dn[r] = {{CNT_W{1'b0}}, wb_en & (wb_reg == 3'(r))}
            + {{CNT_W{1'b0}},
               squash & out_regwrt & (out_rd == 3'(r))};
      uf[r] = up[r] < dn[r];
      cnt_nx[r] = uf[r] ? '0 : CNT_W'(up[r] - dn[r]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        rf[i]  <= '0;
        cnt[i] <= '0;
      end
      err <= 1'b0;
    end else begin
      if (wb_en) rf[wb_reg] <= wb_data;
      for (int i = 0; i < 8; i++) cnt[i] <= cnt_nx[i];
      err <= err | (|uf);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      ex_q      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      ex_q      <= ex_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_instr  = ex_q.instr;
  assign out_pc     = ex_q.pc;
  assign out_r1     = ex_q.r1;
  assign out_r2     = ex_q.r2;
  assign out_regwrt = ex_q.regwrt;
  assign out_rd     = ex_q.rd;

endmodule

// File: tb/tb_decode_stage_hs.sv
// tb_decode_stage_hs: directed + random stimulus against a behavioural
// decode/scoreboard model, with a queue-based output monitor.
module tb_decode_stage_hs;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] r1;
    logic [15:0] r2;
    logic        regwrt;
    logic [2:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic [15:0] in_pc = '0;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_reg = '0;
  logic [15:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_r1;
  logic [15:0] out_r2;
  logic        out_regwrt;
  logic [2:0]  out_rd;
  logic        stall;
  logic        err;

  decode_stage_hs #(.DATA_W(16), .PC_W(16), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_r1(out_r1), .out_r2(out_r2),
    .out_regwrt(out_regwrt), .out_rd(out_rd),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  exp_t        q[$];
  int          m_cnt [8];
  logic [15:0] m_rf [8];
  bit          m_ov;
  bit          m_err;
  bit          m_orw;
  int          m_ord;
  logic [15:0] pc_n = 16'h0100;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_cnt[i] = 0;
      m_rf[i]  = '0;
    end
    m_ov = 0; m_err = 0; m_orw = 0; m_ord = 0;
    q.delete();
  endfunction

  function automatic void decode(input logic [15:0] i, output bit rw,
                                 output int rd, output bit su,
                                 output bit tu);
    logic [4:0] o;
    o  = i[15:11];
    rw = !(o[4:2] == 3'b011 || o[4:1] inside {4'b0000, 4'b0001, 4'b0010}
           || o == 5'b10000);
    casez (o)
      5'b11011, 5'b11010, 5'b111??: rd = int'(i[4:2]);
      5'b10010, 5'b11000:          rd = int'(i[10:8]);
      5'b0011?:                    rd = 7;
      default:                     rd = int'(i[7:5]);
    endcase
    su = !(int'(o) inside {0, 1, 2, 3, 4, 6, 24});
    tu = (int'(o) inside {27, 26, 16, 17, 19}) || (o[4:2] == 3'b111);
  endfunction

  function automatic bit blocked(input int s, input bit we, input int wr);
    return m_cnt[s] > 1 || (m_cnt[s] == 1 && !(we && wr == s));
  endfunction

  function automatic logic [15:0] mk(input logic [4:0] o,
                                     input logic [2:0] s,
                                     input logic [2:0] t,
                                     input logic [2:0] d);
    return {o, s, t, d, 2'b00};
  endfunction

  function automatic logic [15:0] wr_i(input logic [2:0] d);
    return mk(5'b11011, 3'd0, 3'd0, d);
  endfunction

  function automatic logic [15:0] rd_i(input logic [2:0] s);
    return mk(5'b01100, s, 3'd0, 3'd0);
  endfunction

  // One clock cycle: drive at negedge, check comb outputs, advance model.
  task automatic cyc(input bit iv, input logic [15:0] ins, input bit we,
                     input logic [2:0] wr, input logic [15:0] wd,
                     input bit fl, input bit ordy);
    bit   rw, su, tu, haz, fullb, rdy, iss;
    int   rd, s, t, n;
    exp_t e;
    @(negedge clk);
    pc_n = pc_n + 16'd2;
    in_valid = iv; in_instr = ins; in_pc = pc_n;
    wb_en = we; wb_reg = wr; wb_data = wd;
    flush = fl; out_ready = ordy;
    #1;
    decode(ins, rw, rd, su, tu);
    s = int'(ins[10:8]);
    t = int'(ins[7:5]);
    haz   = (su && blocked(s, we, int'(wr))) || (tu && blocked(t, we, int'(wr)));
    fullb = rw && m_cnt[rd] == 3;
    rdy   = !fl && !haz && !fullb && (!m_ov || ordy);
    chk("in_ready", in_ready, rdy);
    chk("stall", stall, iv && (haz || fullb));
    chk("out_valid", out_valid, m_ov);
    chk("err", err, m_err);
    iss = iv && rdy;
    if (iss) begin
      e.instr  = ins;
      e.pc     = pc_n;
      e.r1     = (we && int'(wr) == s) ? wd : m_rf[s];
      e.r2     = (we && int'(wr) == t) ? wd : m_rf[t];
      e.regwrt = rw;
      e.rd     = 3'(rd);
      q.push_back(e);
    end
    for (int r = 0; r < 8; r++) begin
      n = m_cnt[r] + int'(iss && rw && rd == r) - int'(we && int'(wr) == r)
        - int'(fl && m_ov && m_orw && m_ord == r);
      if (n < 0) begin
        m_err = 1;
        n = 0;
      end
      m_cnt[r] = n;
    end
    if (we) m_rf[wr] = wd;
    if (fl) m_ov = 0;
    else if (iss) begin
      m_ov = 1; m_orw = rw; m_ord = rd;
    end else if (m_ov && ordy) m_ov = 0;
  endtask

  task automatic idle(input bit ordy);
    cyc(1'b0, 16'h0000, 1'b0, 3'd0, 16'h0, 1'b0, ordy);
  endtask

  // Monitor: whatever ID/EX presents must equal the oldest expected entry.
  exp_t act_e;
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst && out_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mon_unexpected actual=%0h required=none",
                   {out_instr, out_pc});
        end else begin
          act_e = {out_instr, out_pc, out_r1, out_r2, out_regwrt, out_rd};
          checks++;
          if (act_e !== q[0]) begin
            failures++;
            $display("FAIL mon_idex actual=%0h required=%0h", act_e, q[0]);
          end
          if (out_ready || flush) void'(q.pop_front());
        end
      end
    end
  end

  logic [15:0] add_i;
  logic [15:0] bp_pc;
  logic [2:0]  wr_r;
  bit          we_r;

  initial begin
    model_reset();
    #12 rst = 1'b1;

    // Reset mid-stream with a live entry and two pending writes to r3.
    cyc(1, wr_i(3'd3), 0, 0, 0, 0, 1);
    cyc(1, wr_i(3'd3), 0, 0, 0, 0, 1);
    idle(0);
    chk("pre_rst_valid", out_valid, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_fields", {out_instr, out_pc, out_r1, out_r2, out_regwrt, out_rd}, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", in_ready, 1);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    add_i = mk(5'b11011, 3'd3, 3'd0, 3'd1);
    cyc(1, add_i, 0, 0, 0, 0, 1);
    chk("post_rst_accept", in_ready, 1);
    idle(1);
    chk("post_rst_instr", out_instr, add_i);

    // RAW stall, then issue on the producer's writeback via bypass.
    cyc(1, wr_i(3'd2), 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      cyc(1, rd_i(3'd2), 0, 0, 0, 0, 1);
      chk("raw_stall", stall, 1);
      chk("raw_ready", in_ready, 0);
    end
    cyc(1, rd_i(3'd2), 1, 3'd2, 16'h1234, 0, 1);
    chk("raw_issue", in_ready, 1);
    idle(1);
    chk("raw_bypass", out_r1, 16'h1234);

    // Counter saturation on r5.
    for (int i = 0; i < 3; i++) cyc(1, wr_i(3'd5), 0, 0, 0, 0, 1);
    cyc(1, wr_i(3'd5), 0, 0, 0, 0, 1);
    chk("full_stall", stall, 1);
    cyc(1, wr_i(3'd5), 1, 3'd5, 16'h0055, 0, 1);
    cyc(1, wr_i(3'd5), 0, 0, 0, 0, 1);
    chk("full_issue", in_ready, 1);

    // Backpressure holds ID/EX.
    idle(1);
    cyc(1, rd_i(3'd0), 0, 0, 0, 0, 0);
    bp_pc = pc_n;
    for (int i = 0; i < 3; i++) begin
      cyc(1, rd_i(3'd0), 0, 0, 0, 0, 0);
      chk("bp_ready", in_ready, 0);
      chk("bp_pc", out_pc, bp_pc);
    end
    cyc(1, rd_i(3'd0), 0, 0, 0, 0, 1);
    chk("bp_release", in_ready, 1);
    idle(1);
    chk("bp_next", out_pc, bp_pc + 16'd8);

    // Flush of a regwrt entry composed with a writeback to the same reg.
    cyc(1, wr_i(3'd4), 0, 0, 0, 0, 0);
    cyc(0, 16'h0, 1, 3'd4, 16'h0444, 1, 0);
    chk("flush_ready", in_ready, 0);
    idle(0);
    chk("flush_valid", out_valid, 0);
    chk("flush_err", err, 1);
    cyc(1, rd_i(3'd4), 0, 0, 0, 0, 1);
    chk("flush_cnt0", in_ready, 1);

    // Issue and writeback on r6 in the same cycle keep the count.
    cyc(1, wr_i(3'd6), 0, 0, 0, 0, 1);
    cyc(1, wr_i(3'd6), 1, 3'd6, 16'h0666, 0, 1);
    chk("same_issue", in_ready, 1);
    cyc(1, rd_i(3'd6), 0, 0, 0, 0, 1);
    chk("same_stall", stall, 1);
    cyc(0, 16'h0, 1, 3'd6, 16'h0667, 0, 1);

    // Random traffic.
    for (int k = 0; k < 500; k++) begin
      bit fl;
      we_r = $urandom_range(0, 9) < 4;
      wr_r = 3'($urandom_range(0, 7));
      for (int j = 0; j < 8 && m_cnt[wr_r] == 0; j++)
        wr_r = 3'($urandom_range(0, 7));
      fl = $urandom_range(0, 19) == 0;
      cyc($urandom_range(0, 3) != 0, 16'($urandom), we_r, wr_r,
          16'($urandom), fl, fl ? 1'b0 : ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
